// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Multicycle control sequencer for the 16-bit RISC datapath. A single ALU is
// shared between PC increment (PC+2), branch/jump target calculation and
// register arithmetic. This block steps each instruction through a fixed state
// sequence and drives the selects/strobes for that shared datapath. It also
// counts retired instructions and raises a sticky fault when an instruction
// fetch waits too long.
//
// Parameters
//   MEM_TIMEOUT   consecutive FETCH cycles with mem_ready low before fault
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset
//   start         leave IDLE, or HALTED when no fault is set
//   halt_req      halt at the next retire boundary
//   mem_ready     instruction word valid this cycle (looked at in FETCH only)
//   instr[15:0]   instruction word, opcode = instr[15:12]
//   alu_zero      ALU ZERO flag (looked at in BRANCH only)
//   mem_read      instruction read request
//   ir_write      instruction register load strobe
//   pc_write      ProgramCounter load from ALUOUT
//   alu_srca_sel  0 = PC, 1 = register A
//   alu_srcb_sel  00 = reg B, 01 = const 2, 10 = sext(imm) << 1, 11 = unused
//   alu_op        0 = add, 1 = subtract
//   reg_write     register file write strobe
//   opcode[3:0]   latched opcode of the current instruction
//   busy          high in every state except IDLE and HALTED
//   fault         sticky fetch-timeout flag, cleared only by reset
//   instr_count   retired-instruction counter, wraps 0xFFFF -> 0x0000
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        mem_ready,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  output logic        mem_read,
  output logic        ir_write,
  output logic        pc_write,
  output logic        alu_srca_sel,
  output logic [1:0]  alu_srcb_sel,
  output logic        alu_op,
  output logic        reg_write,
  output logic [3:0]  opcode,
  output logic        busy,
  output logic        fault,
  output logic [15:0] instr_count
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  // The wait counter holds the number of already-elapsed not-ready FETCH
  // cycles, so the timeout fires during the MEM_TIMEOUT-th such cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_DECODE      = 3'd2,
    S_EXEC        = 3'd3,
    S_WRITEBACK   = 3'd4,
    S_BRANCH      = 3'd5,
    S_BRANCH_TAKE = 3'd6,
    S_HALTED      = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_REG = 1'b1;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  state_t            state_q, state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              retire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      opcode_q      <= 4'h0;
      wait_q        <= '0;
      fault_q       <= 1'b0;
      instr_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      wait_q        <= wait_d;
      fault_q       <= fault_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    wait_d        = wait_q;
    fault_d       = fault_q;
    instr_count_d = instr_count_q;
    retire        = 1'b0;

    mem_read      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    alu_srca_sel  = SRCA_PC;
    alu_srcb_sel  = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          // Latch the instruction and use the idle ALU for PC <= PC + 2.
          ir_write     = 1'b1;
          opcode_d     = instr[15:12];
          alu_srca_sel = SRCA_PC;
          alu_srcb_sel = SRCB_TWO;
          alu_op       = ALU_ADD;
          pc_write     = 1'b1;
          wait_d       = '0;
          state_d      = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          wait_d  = '0;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DECODE: begin
        case (opcode_q)
          OP_ADD, OP_SUB: state_d = S_EXEC;
          OP_BEQ:         state_d = S_BRANCH;
          OP_JMP: begin
            // PC already holds PC+2, so the target is relative to that.
            alu_srca_sel = SRCA_PC;
            alu_srcb_sel = SRCB_IMM;
            alu_op       = ALU_ADD;
            pc_write     = 1'b1;
            retire       = 1'b1;
          end
          // HALT and every unassigned opcode retire here; HALT is steered
          // to HALTED by the retire logic below.
          default:        retire = 1'b1;
        endcase
      end

      S_EXEC: begin
        alu_srca_sel = SRCA_REG;
        alu_srcb_sel = SRCB_REG;
        alu_op       = opcode_q[0];
        state_d      = S_WRITEBACK;
      end

      S_WRITEBACK: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end

      S_BRANCH: begin
        // A - B; ZERO means equal.
        alu_srca_sel = SRCA_REG;
        alu_srcb_sel = SRCB_REG;
        alu_op       = ALU_SUB;
        if (alu_zero) state_d = S_BRANCH_TAKE;
        else          retire  = 1'b1;
      end

      S_BRANCH_TAKE: begin
        alu_srca_sel = SRCA_PC;
        alu_srcb_sel = SRCB_IMM;
        alu_op       = ALU_ADD;
        pc_write     = 1'b1;
        retire       = 1'b1;
      end

      S_HALTED: begin
        if (start && !halt_req && !fault_q) state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    // halt_req only matters at this boundary, so an instruction in flight
    // always completes.
    if (retire) begin
      instr_count_d = instr_count_q + 16'd1;
      state_d       = (halt_req || (opcode_q == OP_HALT)) ? S_HALTED : S_FETCH;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign opcode      = opcode_q;
  assign fault       = fault_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A per-instruction micro-step model
// (a queue of remaining steps built at fetch time) predicts every control
// output once per cycle; hand-computed literals pin pulse counts, retire
// counts and boundary behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int MEM_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        mem_ready;
  logic [15:0] instr;
  logic        alu_zero;
  logic        mem_read;
  logic        ir_write;
  logic        pc_write;
  logic        alu_srca_sel;
  logic [1:0]  alu_srcb_sel;
  logic        alu_op;
  logic        reg_write;
  logic [3:0]  opcode;
  logic        busy;
  logic        fault;
  logic [15:0] instr_count;

  fetch_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .halt_req     (halt_req),
    .mem_ready    (mem_ready),
    .instr        (instr),
    .alu_zero     (alu_zero),
    .mem_read     (mem_read),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .alu_srca_sel (alu_srca_sel),
    .alu_srcb_sel (alu_srcb_sel),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .opcode       (opcode),
    .busy         (busy),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  // Model modes and micro-steps.
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_RUN   = 2;
  localparam int M_HALT  = 3;

  localparam int K_DEC  = 0;  // decode cycle, nothing driven
  localparam int K_JMP  = 1;  // decode cycle that loads the jump target
  localparam int K_EXEC = 2;
  localparam int K_WB   = 3;
  localparam int K_BR   = 4;
  localparam int K_TAKE = 5;

  int          m_mode;
  logic [3:0]  m_opcode;
  logic        m_fault;
  logic [15:0] m_count;
  int          m_wait;
  int          m_plan[$];

  int n_cmp  = 0;
  int n_bad  = 0;
  int pcw_n  = 0;
  int regw_n = 0;
  int irw_n  = 0;
  int b_pc, b_reg, b_ir;

  // {mem_read, ir_write, pc_write, srca, srcb[1:0], alu_op, reg_write, busy}
  function automatic logic [8:0] ctrl_now();
    return {mem_read, ir_write, pc_write, alu_srca_sel, alu_srcb_sel,
            alu_op, reg_write, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of the model: predict, compare, then advance as the clock
  // edge will.
  task automatic model_cycle();
    logic [8:0] e;
    int k;
    e = '0;
    if (!reset) begin
      m_mode   = M_IDLE;
      m_opcode = 4'h0;
      m_fault  = 1'b0;
      m_count  = 16'h0000;
      m_wait   = 0;
      m_plan.delete();
    end else begin
      case (m_mode)
        M_FETCH: begin
          e[8] = 1'b1;
          e[0] = 1'b1;
          if (mem_ready) begin
            e[7]   = 1'b1;
            e[6]   = 1'b1;
            e[4:3] = 2'b01;
          end
        end
        M_RUN: begin
          e[0] = 1'b1;
          case (m_plan[0])
            K_JMP:  begin e[6] = 1'b1; e[4:3] = 2'b10; end
            K_EXEC: begin e[5] = 1'b1; e[2] = m_opcode[0]; end
            K_WB:   e[1] = 1'b1;
            K_BR:   begin e[5] = 1'b1; e[2] = 1'b1; end
            K_TAKE: begin e[6] = 1'b1; e[4:3] = 2'b10; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    check("ctrl", 32'(ctrl_now()), 32'(e));
    check("opcode", 32'(opcode), 32'(m_opcode));
    check("fault", 32'(fault), 32'(m_fault));
    check("instr_count", 32'(instr_count), 32'(m_count));

    if (reset) begin
      if (pc_write)  pcw_n++;
      if (reg_write) regw_n++;
      if (ir_write)  irw_n++;
      case (m_mode)
        M_IDLE: if (start) m_mode = M_FETCH;
        M_HALT: if (start && !halt_req && !m_fault) m_mode = M_FETCH;
        M_FETCH: begin
          if (mem_ready) begin
            m_opcode = instr[15:12];
            m_wait   = 0;
            m_plan.delete();
            case (instr[15:12])
              4'h0, 4'h1: begin
                m_plan.push_back(K_DEC);
                m_plan.push_back(K_EXEC);
                m_plan.push_back(K_WB);
              end
              4'h2: begin
                m_plan.push_back(K_DEC);
                m_plan.push_back(K_BR);
              end
              4'h3:    m_plan.push_back(K_JMP);
              default: m_plan.push_back(K_DEC);
            endcase
            m_mode = M_RUN;
          end else begin
            m_wait++;
            if (m_wait == MEM_TIMEOUT) begin
              m_fault = 1'b1;
              m_wait  = 0;
              m_mode  = M_HALT;
            end
          end
        end
        M_RUN: begin
          k = m_plan.pop_front();
          if (k == K_BR && alu_zero) m_plan.push_back(K_TAKE);
          if (m_plan.size() == 0) begin
            m_count = m_count + 16'd1;
            m_mode  = (halt_req || m_opcode == 4'hF) ? M_HALT : M_FETCH;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mark();
    b_pc  = pcw_n;
    b_reg = regw_n;
    b_ir  = irw_n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    halt_req  = 1'b0;
    mem_ready = 1'b0;
    instr     = 16'h0000;
    alu_zero  = 1'b0;
    m_mode    = M_IDLE;
    m_opcode  = 4'h0;
    m_fault   = 1'b0;
    m_count   = 16'h0000;
    m_wait    = 0;

    run(2);
    check("rst_count", 32'(instr_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    reset = 1'b1;
    run(1);

    // ALU R-type stream: 4 cycles per instruction.
    instr     = 16'h0123;
    mem_ready = 1'b1;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    mark();
    run(12);
    check("rtype_pc_writes", 32'(pcw_n - b_pc), 32'd3);
    check("rtype_reg_writes", 32'(regw_n - b_reg), 32'd3);
    check("rtype_count", 32'(instr_count), 32'd3);

    // halt_req raised in EXEC: WRITEBACK still completes.
    run(2);
    halt_req = 1'b1;
    start    = 1'b1;           // ignored while busy
    run(2);
    halt_req = 1'b0;
    start    = 1'b0;
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_count", 32'(instr_count), 32'd4);
    start = 1'b1;
    run(1);
    start = 1'b0;
    check("resume_busy", 32'(busy), 32'h1);

    // BEQ taken then not taken.
    instr    = 16'h2005;
    alu_zero = 1'b1;
    mark();
    run(4);
    check("beq_taken_pc_writes", 32'(pcw_n - b_pc), 32'd2);
    check("beq_taken_count", 32'(instr_count), 32'd5);
    alu_zero = 1'b0;
    mark();
    run(3);
    check("beq_not_taken_pc_writes", 32'(pcw_n - b_pc), 32'd1);
    check("beq_not_taken_count", 32'(instr_count), 32'd6);

    // JMP and NOP.
    instr = 16'h3FFE;
    mark();
    run(2);
    check("jmp_pc_writes", 32'(pcw_n - b_pc), 32'd2);
    check("jmp_count", 32'(instr_count), 32'd7);
    instr = 16'h7000;
    mark();
    run(2);
    check("nop_pc_writes", 32'(pcw_n - b_pc), 32'd1);
    check("nop_reg_writes", 32'(regw_n - b_reg), 32'd0);
    check("nop_count", 32'(instr_count), 32'd8);

    // Subtract R-type.
    instr = 16'h1234;
    mark();
    run(4);
    check("sub_reg_writes", 32'(regw_n - b_reg), 32'd1);
    check("sub_count", 32'(instr_count), 32'd9);

    // HALT opcode.
    instr = 16'hF000;
    run(2);
    check("halt_op_busy", 32'(busy), 32'h0);
    check("halt_op_count", 32'(instr_count), 32'd10);
    check("halt_op_opcode", 32'(opcode), 32'hF);
    instr = 16'h7000;
    start = 1'b1;
    run(1);
    start = 1'b0;

    // Three fetch wait cycles on a NOP: 5 cycles total.
    mem_ready = 1'b0;
    mark();
    run(3);
    mem_ready = 1'b1;
    run(2);
    check("wait_pc_writes", 32'(pcw_n - b_pc), 32'd1);
    check("wait_ir_writes", 32'(irw_n - b_ir), 32'd1);
    check("wait_count", 32'(instr_count), 32'd11);

    // Fetch timeout.
    mem_ready = 1'b0;
    mark();
    run(MEM_TIMEOUT - 1);
    check("timeout_early_fault", 32'(fault), 32'h0);
    check("timeout_early_busy", 32'(busy), 32'h1);
    run(1);
    check("timeout_fault", 32'(fault), 32'h1);
    check("timeout_busy", 32'(busy), 32'h0);
    check("timeout_pc_writes", 32'(pcw_n - b_pc), 32'd0);
    start     = 1'b1;
    mem_ready = 1'b1;
    run(3);
    start = 1'b0;
    check("fault_start_busy", 32'(busy), 32'h0);
    check("fault_sticky", 32'(fault), 32'h1);

    // Asynchronous reset with a fault set.
    reset = 1'b0;
    #1;
    check("areset_ctrl", 32'(ctrl_now()), 32'h0);
    check("areset_fault", 32'(fault), 32'h0);
    run(1);
    reset = 1'b1;

    // Reset asserted during EXEC.
    instr     = 16'h0123;
    mem_ready = 1'b1;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    run(2);
    check("exec_busy_before_reset", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("exec_reset_ctrl", 32'(ctrl_now()), 32'h0);
    check("exec_reset_count", 32'(instr_count), 32'h0);
    check("exec_reset_opcode", 32'(opcode), 32'h0);
    run(1);
    reset = 1'b1;

    // Reset asserted during a fetch wait cycle.
    mem_ready = 1'b0;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    run(1);
    reset = 1'b0;
    #1;
    check("wait_reset_ctrl", 32'(ctrl_now()), 32'h0);
    run(1);
    reset = 1'b1;
    run(1);

    // Counter wrap from a preloaded 0xFFFF.
    force dut.instr_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    run(1);
    release dut.instr_count_q;
    run(1);
    check("preload_count", 32'(instr_count), 32'hFFFF);
    instr     = 16'h7000;
    mem_ready = 1'b1;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    run(2);
    check("wrap_count", 32'(instr_count), 32'h0);
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
